// File: rtl/shift_cmd_fifo.sv
// Command FIFO of {data, rotate amount} pairs feeding an 8-bit barrel shifter.
// Optional sticky overflow flag (ovf port) enabled by defining SHIFT_CMD_FIFO_OVF_EN.
module shift_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_amt,
  output logic [7:0]    data,
  output logic [2:0]    amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
`ifdef SHIFT_CMD_FIFO_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned EW = DW + AW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Head is read straight from storage; zeroed while the queue is empty.
  assign head = mem_q[rd_ptr_q];
  assign data = out_valid ? head[EW-1:AW] : 8'h00;
  assign amt  = out_valid ? head[AW-1:0]  : 3'd0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_amt};
  end

`ifdef SHIFT_CMD_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Directed self-checking bench for shift_cmd_fifo (DEPTH=4), with a rotate-right reference.
module tb_shift_cmd_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [2:0]    in_amt;
  logic [7:0]    data;
  logic [2:0]    amt;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
`ifdef SHIFT_CMD_FIFO_OVF_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  shift_cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .data      (data),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef SHIFT_CMD_FIFO_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] a);
    logic [15:0] dd;
    dd = {d, d} >> a;
    return dd[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_data",      32'(data),      32'h00);
    chk("rst_amt",       32'(amt),       32'd0);
    chk("rst_count",     32'(count),     32'd0);
`ifdef SHIFT_CMD_FIFO_OVF_EN
    chk("rst_ovf",       32'(ovf),       32'd0);
`endif
    #9;
    rst = 1'b0;

    // Basic flow: first edge after reset accepts the push
    in_valid = 1'b1; in_data = 8'b0000_0011; in_amt = 3'd1;
    step();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data",  32'(data),      32'h03);
    chk("basic_amt",   32'(amt),       32'd1);
    chk("basic_count", 32'(count),     32'd1);
    chk("basic_shift", 32'(rotr(data, amt)), 32'h81);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("basic_pop_valid", 32'(out_valid), 32'd0);
    chk("basic_pop_data",  32'(data),      32'h00);
    chk("basic_pop_count", 32'(count),     32'd0);

    // Fill to DEPTH with out_ready low
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h03;
    for (int k = 0; k < 4; k++) begin
      in_amt = 3'(k);
      step();
      chk("fill_count", 32'(count), 32'(k + 1));
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_amt", 32'(amt),      32'd0);

    // Full with push and pop together: pop only, blocked command dropped
    in_data = 8'hFF; in_amt = 3'd5; out_ready = 1'b1;
    step();
    chk("fullpp_count",    32'(count),    32'd3);
    chk("fullpp_in_ready", 32'(in_ready), 32'd1);
    chk("fullpp_head_amt", 32'(amt),      32'd1);
`ifdef SHIFT_CMD_FIFO_OVF_EN
    chk("fullpp_ovf",      32'(ovf),      32'd1);
`endif
    in_valid = 1'b0;
    step();
    chk("drain_amt2", 32'(amt), 32'd2);
    step();
    chk("drain_amt3", 32'(amt), 32'd3);
    chk("drain_data", 32'(data), 32'h03);
    step();
    chk("drain_count", 32'(count),     32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
`ifdef SHIFT_CMD_FIFO_OVF_EN
    chk("ovf_sticky",  32'(ovf),       32'd1);
`endif

    // Continuous push/pop across pointer wrap
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h03;
    for (int k = 0; k < 10; k++) begin
      in_amt = 3'(k % 8);
      step();
      chk("wrap_amt",   32'(amt),   32'(k % 8));
      chk("wrap_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("wrap_end_count", 32'(count), 32'd0);

    // Reset between edges with three queued commands
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h11; in_amt = 3'd1; step();
    in_data = 8'h22; in_amt = 3'd2; step();
    in_data = 8'h33; in_amt = 3'd3; step();
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count",    32'(count),     32'd0);
    chk("midrst_valid",    32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready),  32'd1);
    chk("midrst_data",     32'(data),      32'h00);
`ifdef SHIFT_CMD_FIFO_OVF_EN
    chk("midrst_ovf",      32'(ovf),       32'd0);
`endif
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd7;
    step();
    chk("postrst_data",  32'(data),  32'hA5);
    chk("postrst_amt",   32'(amt),   32'd7);
    chk("postrst_count", 32'(count), 32'd1);
    chk("postrst_shift", 32'(rotr(data, amt)), 32'h4B);

    // Pop it, then pop on empty for three cycles with idle input noise
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("last_pop_count", 32'(count), 32'd0);
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h5A + k); in_amt = 3'(k + 2);
      step();
      chk("empty_count", 32'(count),     32'd0);
      chk("empty_data",  32'(data),      32'h00);
      chk("empty_amt",   32'(amt),       32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
